ftq: RTL and testbench
======================

Name: ftq

Overview:
- Fetch Target Queue: circular buffer between the BPU and the IFU.
- Accepts P0 next-line blocks and P1 main-predictor overrides from the BPU, then hands blocks in order to the IFU.
- Collects per-block resolution from the backend at commit and returns training meta to the BPU.
- On the BPU side it is the consumer of predictions and the producer of training updates.

Parameters:
- FTQ_SIZE, 8, number of entries; power of two, ≥4.
- ADDR_WIDTH, 32, PC width.
- FETCH_WIDTH, 4, max instructions per block.
- PTR_W, $clog2(FTQ_SIZE)+1, pointer width including the wrap bit (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- backend_flush_i  in  1  squash all uncommitted entries
- bpu_p0_i  in  ftq_block_t  P0 block (valid, start_pc, length, is_cross_cacheline, predicted_taken, predict_valid)
- bpu_p1_i  in  ftq_block_t  P1 override for the block written last cycle
- bpu_meta_i  in  bpu_ftq_meta_t  predictor meta for the block written last cycle
- bpu_ftq_full_o  out  1  BPU must not issue P0
- ifu_block_o  out  ftq_block_t  head-of-fetch block
- ifu_ftq_id_o  out  PTR_W-1  entry index of ifu_block_o
- ifu_accept_i  in  1  IFU consumed ifu_block_o
- ifu_flush_o  out  1  IFU must drop in-flight fetches after a P1 rewind
- commit_valid_i  in  1  backend resolves the head-of-commit block
- commit_ftq_id_i  in  PTR_W-1  must equal the commit pointer index
- commit_is_taken_i  in  1  resolved direction
- commit_branch_type_i  in  2  BRANCH_TYPE_*
- commit_jump_target_i  in  ADDR_WIDTH  resolved target
- commit_fall_through_i  in  ADDR_WIDTH  resolved fall-through
- commit_ftb_dirty_i  in  1  FTB entry found polluted
- bpu_train_o  out  ftq_bpu_meta_t  training packet to the BPU

Behaviour:
- Pointers: bpu_ptr (write), ifu_ptr (fetch), comm_ptr (retire), each PTR_W bits.
- Pointer invariant: comm_ptr ≤ ifu_ptr ≤ bpu_ptr, modulo arithmetic using the wrap bit.
- Occupancy is bpu_ptr − comm_ptr.
- Reset (async): all pointers 0; last_wr 0; all entry valid bits 0; bpu_train_o 0; ifu_flush_o 0.
- bpu_ftq_full_o is combinational and equals (occupancy ≥ FTQ_SIZE−1). The spare slot absorbs BPU P0/P1 skew.
- Write priority per cycle: flush > P1 > P0.
- P0 write: if bpu_p0_i.valid, bpu_p1_i.valid=0, occupancy<FTQ_SIZE and no flush, then write the entry at bpu_ptr, increment bpu_ptr, set last_wr=1. Otherwise last_wr=0.
- P0 arriving while occupancy=FTQ_SIZE is dropped silently.
- P1 override: if bpu_p1_i.valid and last_wr, overwrite block fields of entry bpu_ptr−1. That cycle's P0 is discarded (wrong path) and bpu_ptr does not advance. P1 without last_wr is ignored.
- P1 rewind: if ifu_ptr == bpu_ptr (entry bpu_ptr−1 already handed to the IFU), set ifu_ptr←bpu_ptr−1 and pulse ifu_flush_o for 1 cycle (registered).
- Meta capture: when last_wr=1, bpu_meta_i is written into entry bpu_ptr−1 that cycle, whether or not P1 is valid.
- IFU output: ifu_block_o is combinational from entry[ifu_ptr] with valid = (ifu_ptr≠bpu_ptr) & ~backend_flush_i; otherwise all zero. ifu_accept_i with valid increments ifu_ptr. Accept on invalid output is ignored.
- Commit: commit_valid_i with commit_ftq_id_i == comm_ptr index and comm_ptr≠ifu_ptr retires the entry and increments comm_ptr.
- Training output: next cycle, bpu_train_o.valid=1, carrying stored start_pc, is_cross_cacheline, predicted_taken, bpu meta (ftb_hit, ftb_hit_index, tage fields) plus the commit_* fields; 1-cycle registered latency. Otherwise bpu_train_o=0.
- Illegal commit: a mismatched id is ignored and triggers a SIMULATION assertion.
- Flush: commit of the same cycle is processed first. Then bpu_ptr←ifu_ptr←comm_ptr_next, last_wr←0, and BPU/IFU inputs that cycle are ignored. Training output is unaffected by flush.
- Wrap-around: pointers wrap naturally. full/empty are distinguished by the wrap bit.

Decomposition:
- core_types / bpu_types package: ftq_block_t, bpu_ftq_meta_t, ftq_bpu_meta_t, BRANCH_TYPE_* constants, FTQ_SIZE.
- New ftq_entry_t (block fields + bpu meta) belongs in bpu_types.
- One sub-module: ftq_ptr_ctrl, holding the pointer/occupancy/full logic. Entry storage stays a flop array in ftq.

Test Plan:
- Fill: 7 consecutive P0 with no IFU/commit → occupancy 7; bpu_ftq_full_o=1 from cycle 7; 8th P0 with full ignored by BPU; an injected 8th P0 is written, a 9th is dropped.
- P1 override: P0 pc=0x1c000000 at cycle t, P1 at t+1 with length 2, P0 pc=0x1c000010 at t+1 → entry0.length=2, bpu_ptr=1, the 0x1c000010 block is absent.
- P1 rewind: IFU accepts entry0 in cycle t, P1 arrives t+1 → ifu_ptr returns to 0; ifu_flush_o=1 at t+2; ifu_block_o shows the overridden block.
- Commit/train: commit id 0, taken, target 0x1c000100 → bpu_train_o.valid=1 next cycle with start_pc 0x1c000000, is_taken=1, stored ftb_hit; comm_ptr=1.
- Flush: 5 entries, ifu_ptr=3, comm_ptr=1, flush with a same-cycle commit of id 1 → bpu_ptr=ifu_ptr=comm_ptr=2; ifu_block_o invalid.
- Wrap: stream 20 blocks through with 1-cycle IFU/commit → all 20 trainings in order with correct PCs; no false full.

Source files
------------

// File: rtl/ftq_pkg.sv
// Shared types and sizing for the fetch target queue and its BPU/IFU/backend interfaces.
package ftq_pkg;

    localparam int unsigned FTQ_SIZE    = 8;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned FETCH_WIDTH = 4;
    localparam int unsigned IDX_W       = $clog2(FTQ_SIZE);
    localparam int unsigned PTR_W       = IDX_W + 1;
    localparam int unsigned LEN_W       = $clog2(FETCH_WIDTH) + 1;
    localparam int unsigned FTB_IDX_W   = 4;

    localparam logic [1:0] BRANCH_TYPE_NONE = 2'd0;
    localparam logic [1:0] BRANCH_TYPE_COND = 2'd1;
    localparam logic [1:0] BRANCH_TYPE_JUMP = 2'd2;
    localparam logic [1:0] BRANCH_TYPE_RET  = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic [ADDR_WIDTH-1:0]  start_pc;
        logic [LEN_W-1:0]       length;
        logic                   is_cross_cacheline;
        logic                   predicted_taken;
        logic                   predict_valid;
    } ftq_block_t;

    typedef struct packed {
        logic                   ftb_hit;
        logic [FTB_IDX_W-1:0]   ftb_hit_index;
        logic [2:0]             tage_provider;
        logic [2:0]             tage_provider_ctr;
        logic                   tage_alt_pred;
    } bpu_ftq_meta_t;

    typedef struct packed {
        ftq_block_t             block;
        bpu_ftq_meta_t          meta;
    } ftq_entry_t;

    typedef struct packed {
        logic                   valid;
        logic [ADDR_WIDTH-1:0]  start_pc;
        logic                   is_cross_cacheline;
        logic                   predicted_taken;
        logic                   ftb_hit;
        logic [FTB_IDX_W-1:0]   ftb_hit_index;
        logic [2:0]             tage_provider;
        logic [2:0]             tage_provider_ctr;
        logic                   tage_alt_pred;
        logic                   is_taken;
        logic [1:0]             branch_type;
        logic [ADDR_WIDTH-1:0]  jump_target;
        logic [ADDR_WIDTH-1:0]  fall_through;
        logic                   ftb_dirty;
    } ftq_bpu_meta_t;

    function automatic ftq_bpu_meta_t make_train(
        input ftq_entry_t            e,
        input logic                  taken,
        input logic [1:0]            btype,
        input logic [ADDR_WIDTH-1:0] target,
        input logic [ADDR_WIDTH-1:0] fall,
        input logic                  dirty
    );
        ftq_bpu_meta_t t;
        t                    = '0;
        t.valid              = 1'b1;
        t.start_pc           = e.block.start_pc;
        t.is_cross_cacheline = e.block.is_cross_cacheline;
        t.predicted_taken    = e.block.predicted_taken;
        t.ftb_hit            = e.meta.ftb_hit;
        t.ftb_hit_index      = e.meta.ftb_hit_index;
        t.tage_provider      = e.meta.tage_provider;
        t.tage_provider_ctr  = e.meta.tage_provider_ctr;
        t.tage_alt_pred      = e.meta.tage_alt_pred;
        t.is_taken           = taken;
        t.branch_type        = btype;
        t.jump_target        = target;
        t.fall_through       = fall;
        t.ftb_dirty          = dirty;
        return t;
    endfunction

endpackage

// File: rtl/ftq_ptr_ctrl.sv
// Write/fetch/commit pointer bookkeeping for the FTQ: occupancy, full, write gating, P1 rewind.
module ftq_ptr_ctrl
    import ftq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             p0_valid,
    input  logic             p1_valid,
    input  logic             ifu_fire,
    input  logic             commit_valid,
    input  logic [IDX_W-1:0] commit_id,
    output logic [PTR_W-1:0] bpu_ptr,
    output logic [PTR_W-1:0] ifu_ptr,
    output logic [PTR_W-1:0] comm_ptr,
    output logic             last_wr,
    output logic             full,
    output logic             ifu_pending,
    output logic             p0_wr,
    output logic             p1_wr,
    output logic             commit_fire,
    output logic             ifu_flush
);

    localparam logic [PTR_W-1:0] SIZE = PTR_W'(FTQ_SIZE);

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] bpu_prev;
    logic [PTR_W-1:0] ifu_after;
    logic [PTR_W-1:0] comm_next;
    logic             rewind;

    always_comb begin
        occupancy   = bpu_ptr - comm_ptr;
        full        = occupancy >= (SIZE - PTR_W'(1));
        ifu_pending = ifu_ptr != bpu_ptr;
        commit_fire = commit_valid && (commit_id == comm_ptr[IDX_W-1:0]) && (comm_ptr != ifu_ptr);
        p0_wr       = p0_valid && !p1_valid && (occupancy < SIZE) && !flush;
        p1_wr       = p1_valid && last_wr && !flush;
        bpu_prev    = bpu_ptr - PTR_W'(1);
        ifu_after   = ifu_ptr + PTR_W'(ifu_fire);
        // The overridden block is the newest one, so the IFU has it exactly when it
        // has caught up with bpu_ptr, including an accept of it in this same cycle.
        rewind      = p1_wr && (ifu_after == bpu_ptr);
        comm_next   = comm_ptr + PTR_W'(commit_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpu_ptr   <= '0;
            ifu_ptr   <= '0;
            comm_ptr  <= '0;
            last_wr   <= 1'b0;
            ifu_flush <= 1'b0;
        end else begin
            comm_ptr  <= comm_next;
            ifu_flush <= rewind;
            if (flush) begin
                bpu_ptr <= comm_next;
                ifu_ptr <= comm_next;
                last_wr <= 1'b0;
            end else begin
                bpu_ptr <= bpu_ptr + PTR_W'(p0_wr);
                last_wr <= p0_wr;
                ifu_ptr <= rewind ? bpu_prev : ifu_after;
            end
        end
    end

endmodule

// File: rtl/ftq.sv
// Fetch target queue: buffers BPU blocks for the IFU and returns commit-time training to the BPU.
module ftq
    import ftq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  backend_flush_i,
    input  ftq_block_t            bpu_p0_i,
    input  ftq_block_t            bpu_p1_i,
    input  bpu_ftq_meta_t         bpu_meta_i,
    output logic                  bpu_ftq_full_o,
    output ftq_block_t            ifu_block_o,
    output logic [PTR_W-2:0]      ifu_ftq_id_o,
    input  logic                  ifu_accept_i,
    output logic                  ifu_flush_o,
    input  logic                  commit_valid_i,
    input  logic [PTR_W-2:0]      commit_ftq_id_i,
    input  logic                  commit_is_taken_i,
    input  logic [1:0]            commit_branch_type_i,
    input  logic [ADDR_WIDTH-1:0] commit_jump_target_i,
    input  logic [ADDR_WIDTH-1:0] commit_fall_through_i,
    input  logic                  commit_ftb_dirty_i,
    output ftq_bpu_meta_t         bpu_train_o
);

    ftq_entry_t       entries [FTQ_SIZE];
    logic [PTR_W-1:0] bpu_ptr, ifu_ptr, comm_ptr;
    logic [IDX_W-1:0] bpu_idx, prev_idx, ifu_idx, comm_idx;
    logic             last_wr, ifu_pending, ifu_fire, p0_wr, p1_wr, commit_fire;

    assign bpu_idx      = bpu_ptr[IDX_W-1:0];
    assign prev_idx     = bpu_idx - IDX_W'(1);
    assign ifu_idx      = ifu_ptr[IDX_W-1:0];
    assign comm_idx     = comm_ptr[IDX_W-1:0];
    assign ifu_ftq_id_o = ifu_idx;
    assign ifu_fire     = ifu_block_o.valid && ifu_accept_i;

    ftq_ptr_ctrl u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (backend_flush_i),
        .p0_valid     (bpu_p0_i.valid),
        .p1_valid     (bpu_p1_i.valid),
        .ifu_fire     (ifu_fire),
        .commit_valid (commit_valid_i),
        .commit_id    (commit_ftq_id_i),
        .bpu_ptr      (bpu_ptr),
        .ifu_ptr      (ifu_ptr),
        .comm_ptr     (comm_ptr),
        .last_wr      (last_wr),
        .full         (bpu_ftq_full_o),
        .ifu_pending  (ifu_pending),
        .p0_wr        (p0_wr),
        .p1_wr        (p1_wr),
        .commit_fire  (commit_fire),
        .ifu_flush    (ifu_flush_o)
    );

    always_comb begin
        ifu_block_o = '0;
        if (ifu_pending && !backend_flush_i && entries[ifu_idx].block.valid) begin
            ifu_block_o = entries[ifu_idx].block;
        end
    end

    // Entry valid bits live in block.valid; every live entry is uncommitted, so a flush clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FTQ_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (backend_flush_i) begin
            for (int unsigned i = 0; i < FTQ_SIZE; i++) begin
                entries[i].block.valid <= 1'b0;
            end
        end else begin
            if (commit_fire) begin
                entries[comm_idx].block.valid <= 1'b0;
            end
            if (last_wr) begin
                entries[prev_idx].meta <= bpu_meta_i;
            end
            if (p1_wr) begin
                entries[prev_idx].block <= bpu_p1_i;
            end
            if (p0_wr) begin
                entries[bpu_idx].block <= bpu_p0_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bpu_train_o <= '0;
        end else if (commit_fire) begin
            bpu_train_o <= make_train(entries[comm_idx], commit_is_taken_i, commit_branch_type_i,
                                      commit_jump_target_i, commit_fall_through_i, commit_ftb_dirty_i);
        end else begin
            bpu_train_o <= '0;
        end
    end

    a_commit_id: assert property (@(posedge clk) disable iff (rst)
        commit_valid_i |-> (commit_ftq_id_i == comm_idx));

endmodule

// File: tb/tb_ftq.sv
// Bench for ftq: fill table, directed P1/commit/flush/wrap sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_ftq;
    import ftq_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  backend_flush_i;
    ftq_block_t            bpu_p0_i, bpu_p1_i, ifu_block_o;
    bpu_ftq_meta_t         bpu_meta_i;
    logic                  bpu_ftq_full_o, ifu_accept_i, ifu_flush_o;
    logic [PTR_W-2:0]      ifu_ftq_id_o, commit_ftq_id_i;
    logic                  commit_valid_i, commit_is_taken_i, commit_ftb_dirty_i;
    logic [1:0]            commit_branch_type_i;
    logic [ADDR_WIDTH-1:0] commit_jump_target_i, commit_fall_through_i;
    ftq_bpu_meta_t         bpu_train_o;

    always #5 clk = ~clk;

    ftq dut (
        .clk                   (clk),
        .rst                   (rst),
        .backend_flush_i       (backend_flush_i),
        .bpu_p0_i              (bpu_p0_i),
        .bpu_p1_i              (bpu_p1_i),
        .bpu_meta_i            (bpu_meta_i),
        .bpu_ftq_full_o        (bpu_ftq_full_o),
        .ifu_block_o           (ifu_block_o),
        .ifu_ftq_id_o          (ifu_ftq_id_o),
        .ifu_accept_i          (ifu_accept_i),
        .ifu_flush_o           (ifu_flush_o),
        .commit_valid_i        (commit_valid_i),
        .commit_ftq_id_i       (commit_ftq_id_i),
        .commit_is_taken_i     (commit_is_taken_i),
        .commit_branch_type_i  (commit_branch_type_i),
        .commit_jump_target_i  (commit_jump_target_i),
        .commit_fall_through_i (commit_fall_through_i),
        .commit_ftb_dirty_i    (commit_ftb_dirty_i),
        .bpu_train_o           (bpu_train_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: unbounded integer positions, slot = position mod FTQ_SIZE.
    ftq_entry_t            mq [FTQ_SIZE];
    int                    m_bpu, m_ifu, m_comm;
    bit                    m_last, m_iflush;
    ftq_bpu_meta_t         m_train;
    logic [ADDR_WIDTH-1:0] trained [$];

    typedef struct {
        bit                    p0v;
        logic [ADDR_WIDTH-1:0] pc;
        bit                    exp_full;
        bit                    exp_v;
        logic [ADDR_WIDTH-1:0] exp_pc;
    } fill_vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ftq_block_t mkblk(input logic [ADDR_WIDTH-1:0] pc, input int len);
        ftq_block_t b;
        b = '0;
        b.valid = 1'b1;
        b.start_pc = pc;
        b.length = LEN_W'(len);
        b.predict_valid = 1'b1;
        return b;
    endfunction

    function automatic ftq_block_t rblk();
        ftq_block_t b;
        b.valid = 1'b1;
        b.start_pc = $urandom;
        b.length = LEN_W'($urandom_range(1, FETCH_WIDTH));
        b.is_cross_cacheline = 1'($urandom_range(0, 1));
        b.predicted_taken = 1'($urandom_range(0, 1));
        b.predict_valid = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic bpu_ftq_meta_t rmeta();
        logic [31:0] r;
        r = $urandom;
        return r[$bits(bpu_ftq_meta_t)-1:0];
    endfunction

    task automatic idle();
        backend_flush_i = 1'b0;
        bpu_p0_i = '0;
        bpu_p1_i = '0;
        bpu_meta_i = '0;
        ifu_accept_i = 1'b0;
        commit_valid_i = 1'b0;
        commit_ftq_id_i = '0;
        commit_is_taken_i = 1'b0;
        commit_branch_type_i = BRANCH_TYPE_NONE;
        commit_jump_target_i = '0;
        commit_fall_through_i = '0;
        commit_ftb_dirty_i = 1'b0;
    endtask

    task automatic model_reset();
        m_bpu = 0;
        m_ifu = 0;
        m_comm = 0;
        m_last = 0;
        m_iflush = 0;
        m_train = '0;
        foreach (mq[i]) mq[i] = '0;
        trained.delete();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Called at posedge+1 with inputs applied; checks combinational outputs, advances the
    // model across the edge, then checks registered outputs.
    task automatic step();
        int occ, ifu_after;
        bit ifu_v, c_ok, p1_ok, p0_ok;
        ftq_block_t eb;
        ftq_entry_t ce;
        @(negedge clk);
        occ = m_bpu - m_comm;
        ifu_v = (m_ifu < m_bpu) && !backend_flush_i;
        eb = '0;
        if (ifu_v) eb = mq[m_ifu % FTQ_SIZE].block;
        chk("full", 128'(bpu_ftq_full_o), 128'(occ >= int'(FTQ_SIZE) - 1));
        chk("ifu_block", 128'(ifu_block_o), 128'(eb));
        chk("ifu_id", 128'(ifu_ftq_id_o), 128'(m_ifu % FTQ_SIZE));

        c_ok = commit_valid_i && (int'(commit_ftq_id_i) == m_comm % FTQ_SIZE) && (m_comm < m_ifu);
        m_train = '0;
        if (c_ok) begin
            ce = mq[m_comm % FTQ_SIZE];
            m_train.valid = 1'b1;
            m_train.start_pc = ce.block.start_pc;
            m_train.is_cross_cacheline = ce.block.is_cross_cacheline;
            m_train.predicted_taken = ce.block.predicted_taken;
            m_train.ftb_hit = ce.meta.ftb_hit;
            m_train.ftb_hit_index = ce.meta.ftb_hit_index;
            m_train.tage_provider = ce.meta.tage_provider;
            m_train.tage_provider_ctr = ce.meta.tage_provider_ctr;
            m_train.tage_alt_pred = ce.meta.tage_alt_pred;
            m_train.is_taken = commit_is_taken_i;
            m_train.branch_type = commit_branch_type_i;
            m_train.jump_target = commit_jump_target_i;
            m_train.fall_through = commit_fall_through_i;
            m_train.ftb_dirty = commit_ftb_dirty_i;
            m_comm++;
        end
        m_iflush = 0;
        if (backend_flush_i) begin
            m_bpu = m_comm;
            m_ifu = m_comm;
            m_last = 0;
        end else begin
            ifu_after = m_ifu + ((ifu_v && ifu_accept_i) ? 1 : 0);
            p1_ok = bpu_p1_i.valid && m_last;
            if (m_last) mq[(m_bpu - 1) % FTQ_SIZE].meta = bpu_meta_i;
            if (p1_ok) begin
                mq[(m_bpu - 1) % FTQ_SIZE].block = bpu_p1_i;
                if (ifu_after == m_bpu) begin
                    ifu_after = m_bpu - 1;
                    m_iflush = 1;
                end
            end
            p0_ok = bpu_p0_i.valid && !bpu_p1_i.valid && (occ < int'(FTQ_SIZE));
            if (p0_ok) begin
                mq[m_bpu % FTQ_SIZE].block = bpu_p0_i;
                m_bpu++;
            end
            m_last = p0_ok;
            m_ifu = ifu_after;
        end
        @(posedge clk);
        #1;
        chk("train", 128'(bpu_train_o), 128'(m_train));
        chk("ifu_flush", 128'(ifu_flush_o), 128'(m_iflush));
        if (bpu_train_o.valid) trained.push_back(bpu_train_o.start_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t tbl [10];
        int issued;
        tbl[0] = '{1'b1, 32'h1000, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h1010, 1'b0, 1'b1, 32'h1000};
        tbl[2] = '{1'b1, 32'h1020, 1'b0, 1'b1, 32'h1000};
        tbl[3] = '{1'b1, 32'h1030, 1'b0, 1'b1, 32'h1000};
        tbl[4] = '{1'b1, 32'h1040, 1'b0, 1'b1, 32'h1000};
        tbl[5] = '{1'b1, 32'h1050, 1'b0, 1'b1, 32'h1000};
        tbl[6] = '{1'b1, 32'h1060, 1'b0, 1'b1, 32'h1000};
        tbl[7] = '{1'b1, 32'h1070, 1'b1, 1'b1, 32'h1000};
        tbl[8] = '{1'b1, 32'h1080, 1'b1, 1'b1, 32'h1000};
        tbl[9] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h1000};

        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_train", 128'(bpu_train_o), 128'(0));
        chk("rst_ifu_flush", 128'(ifu_flush_o), 128'(0));
        chk("rst_full", 128'(bpu_ftq_full_o), 128'(0));
        chk("rst_ifu_block", 128'(ifu_block_o), 128'(0));

        // Fill past the full hint: 8th write lands, 9th is dropped
        foreach (tbl[i]) begin
            idle();
            bpu_p0_i = mkblk(tbl[i].pc, 4);
            bpu_p0_i.valid = tbl[i].p0v;
            #1;
            chk("fill_full", 128'(bpu_ftq_full_o), 128'(tbl[i].exp_full));
            chk("fill_ifu_valid", 128'(ifu_block_o.valid), 128'(tbl[i].exp_v));
            chk("fill_ifu_pc", 128'(ifu_block_o.start_pc), 128'(tbl[i].exp_pc));
            step();
        end
        for (int k = 0; k < 9; k++) begin
            idle();
            ifu_accept_i = 1'b1;
            #1;
            if (k < 8) chk("drain_pc", 128'(ifu_block_o.start_pc), 128'(32'h1000 + 32'(16 * k)));
            else chk("drain_empty", 128'(ifu_block_o.valid), 128'(0));
            step();
        end

        // P1 override with a same-cycle wrong-path P0, then commit/train
        do_reset();
        idle();
        bpu_p0_i = mkblk(32'h1c000000, 4);
        step();
        idle();
        bpu_p1_i = mkblk(32'h1c000000, 2);
        bpu_p0_i = mkblk(32'h1c000010, 4);
        bpu_meta_i = '{ftb_hit: 1'b1, ftb_hit_index: 4'd5, tage_provider: 3'd3,
                       tage_provider_ctr: 3'd6, tage_alt_pred: 1'b1};
        step();
        idle();
        ifu_accept_i = 1'b1;
        #1;
        chk("p1_len", 128'(ifu_block_o.length), 128'(2));
        chk("p1_pc", 128'(ifu_block_o.start_pc), 128'(32'h1c000000));
        step();
        idle();
        commit_valid_i = 1'b1;
        commit_ftq_id_i = '0;
        commit_is_taken_i = 1'b1;
        commit_branch_type_i = BRANCH_TYPE_JUMP;
        commit_jump_target_i = 32'h1c000100;
        commit_fall_through_i = 32'h1c000008;
        #1;
        chk("p1_wrong_path_absent", 128'(ifu_block_o.valid), 128'(0));
        step();
        chk("train_valid", 128'(bpu_train_o.valid), 128'(1));
        chk("train_pc", 128'(bpu_train_o.start_pc), 128'(32'h1c000000));
        chk("train_taken", 128'(bpu_train_o.is_taken), 128'(1));
        chk("train_ftb_hit", 128'(bpu_train_o.ftb_hit), 128'(1));
        chk("train_target", 128'(bpu_train_o.jump_target), 128'(32'h1c000100));

        // P1 rewind: IFU takes the newest block in the same cycle its override arrives
        idle();
        bpu_p0_i = mkblk(32'h1c000020, 4);
        step();
        idle();
        ifu_accept_i = 1'b1;
        bpu_p1_i = mkblk(32'h1c000020, 1);
        #1;
        chk("rewind_pre_valid", 128'(ifu_block_o.valid), 128'(1));
        step();
        chk("rewind_flush", 128'(ifu_flush_o), 128'(1));
        idle();
        #1;
        chk("rewind_valid", 128'(ifu_block_o.valid), 128'(1));
        chk("rewind_id", 128'(ifu_ftq_id_o), 128'(1));
        chk("rewind_len", 128'(ifu_block_o.length), 128'(1));
        step();
        chk("rewind_pulse_end", 128'(ifu_flush_o), 128'(0));

        // Backend flush with a same-cycle commit
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            bpu_p0_i = mkblk(32'h30000000 + 32'(16 * i), 4);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            ifu_accept_i = 1'b1;
            if (i == 1) begin
                commit_valid_i = 1'b1;
                commit_ftq_id_i = '0;
            end
            step();
        end
        idle();
        backend_flush_i = 1'b1;
        commit_valid_i = 1'b1;
        commit_ftq_id_i = (PTR_W-1)'(1);
        bpu_p0_i = mkblk(32'h3fff0000, 4);
        ifu_accept_i = 1'b1;
        #1;
        chk("flush_ifu_invalid", 128'(ifu_block_o.valid), 128'(0));
        step();
        chk("flush_train_valid", 128'(bpu_train_o.valid), 128'(1));
        chk("flush_train_pc", 128'(bpu_train_o.start_pc), 128'(32'h30000010));
        idle();
        #1;
        chk("post_flush_id", 128'(ifu_ftq_id_o), 128'(2));
        chk("post_flush_valid", 128'(ifu_block_o.valid), 128'(0));
        chk("post_flush_full", 128'(bpu_ftq_full_o), 128'(0));
        step();
        idle();
        bpu_p0_i = mkblk(32'h30000100, 4);
        step();
        idle();
        #1;
        chk("post_flush_slot", 128'(ifu_ftq_id_o), 128'(2));
        chk("post_flush_pc", 128'(ifu_block_o.start_pc), 128'(32'h30000100));
        step();

        // Wrap: 20 blocks streamed with 1-cycle IFU and commit
        do_reset();
        issued = 0;
        for (int c = 0; c < 80 && trained.size() < 20; c++) begin
            idle();
            if (issued < 20) begin
                bpu_p0_i = mkblk(32'h20000000 + 32'(16 * issued), 4);
                issued++;
            end
            ifu_accept_i = 1'b1;
            if (m_comm < m_ifu) begin
                commit_valid_i = 1'b1;
                commit_ftq_id_i = (PTR_W-1)'(m_comm % FTQ_SIZE);
                commit_fall_through_i = 32'h20000010;
            end
            step();
        end
        chk("wrap_count", 128'(trained.size()), 128'(20));
        foreach (trained[i]) chk("wrap_pc", 128'(trained[i]), 128'(32'h20000000 + 32'(16 * i)));

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7) bpu_p0_i = rblk();
            if ($urandom_range(0, 9) < 2) bpu_p1_i = rblk();
            bpu_meta_i = rmeta();
            ifu_accept_i = 1'($urandom_range(0, 1));
            commit_valid_i = 1'($urandom_range(0, 1));
            commit_ftq_id_i = (PTR_W-1)'(m_comm % FTQ_SIZE);
            commit_is_taken_i = 1'($urandom_range(0, 1));
            commit_branch_type_i = 2'($urandom_range(0, 3));
            commit_jump_target_i = $urandom;
            commit_fall_through_i = $urandom;
            commit_ftb_dirty_i = 1'($urandom_range(0, 1));
            backend_flush_i = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
